q2_clock_seq: RTL

//  Synchronous successor to the discrete RC clock: derives the machine's timing strobes from one

---
 rtl/q2_clock_pkg.sv | 16 +
 rtl/q2_clock_seq_if.sv | 36 +++
 rtl/q2_button_sync.sv | 28 ++
 rtl/q2_clock_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/q2_clock_pkg.sv
// Shared types for the q2 clock sequencer: run-state encoding and phase-counter width helper.
// Used by q2_clock_seq_if, q2_button_sync and q2_clock_seq.
package q2_clock_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } q2_state_t;

    // Width of a counter holding 0..nphase-1; never below one bit.
    function automatic int phase_w(input int nphase);
        return (nphase <= 2) ? 1 : $clog2(nphase);
    endfunction

endpackage

// File: rtl/q2_clock_seq_if.sv
// Control/strobe bundle of the q2 clock sequencer. Optional nstep button under Q2_CLOCK_STEP_EN.
// sc/ws are single-clk enables qualified by clk; there is no valid/ready backpressure on this bundle.
interface q2_clock_seq_if #(
    parameter int DIV_W  = 8,
    parameter int NPHASE = 4
);
    import q2_clock_pkg::*;

    localparam int PH_W = phase_w(NPHASE);

    logic             nstart;
    logic             nstop;
`ifdef Q2_CLOCK_STEP_EN
    logic             nstep;
`endif
    logic             cdiv;
    logic [DIV_W-1:0] div;
    logic             running;
    logic [PH_W-1:0]  phase;
    logic             sc;
    logic             ws;
    q2_state_t        dbg_state;

`ifdef Q2_CLOCK_STEP_EN
    modport master (output nstart, nstop, nstep, cdiv, div,
                    input  running, phase, sc, ws, dbg_state);
    modport slave  (input  nstart, nstop, nstep, cdiv, div,
                    output running, phase, sc, ws, dbg_state);
`else
    modport master (output nstart, nstop, cdiv, div,
                    input  running, phase, sc, ws, dbg_state);
    modport slave  (input  nstart, nstop, cdiv, div,
                    output running, phase, sc, ws, dbg_state);
`endif

endinterface

// File: rtl/q2_button_sync.sv
// Synchronises one active-low asynchronous button and emits a 1-clk pulse on each press.
// A held button yields a single pulse; the chain resets to the released (high) level.
module q2_button_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Falling edge of the synchronised level is the press.
    assign press = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/q2_clock_seq.sv
// Clock sequencer: run/stop FSM, programmable tick divider, phase counter and sc/ws strobes.
// Defining Q2_CLOCK_STEP_EN adds the nstep button (single machine cycle from STOPPED).
module q2_clock_seq
    import q2_clock_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int NPHASE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    q2_clock_seq_if.slave  bus
);

    localparam int PH_W = phase_w(NPHASE);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NPHASE - 1);

    q2_state_t        state_q, state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [PH_W-1:0]  phase_q;
    logic             sc_q, ws_q;
    logic             start_p, stop_p;
    logic             tick, last_phase;

    q2_button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk(clk), .rst(rst), .btn_n(bus.nstart), .press(start_p)
    );

    q2_button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .clk(clk), .rst(rst), .btn_n(bus.nstop), .press(stop_p)
    );

`ifdef Q2_CLOCK_STEP_EN
    logic step_p;

    q2_button_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clk(clk), .rst(rst), .btn_n(bus.nstep), .press(step_p)
    );
`endif

    assign tick       = (state_q != STOPPED) && (cnt_q == '0);
    assign last_phase = (phase_q == LAST_PHASE);

    // Stop always beats start; STOPPING only retires on the tick that closes the word cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: begin
                if (start_p && !stop_p) begin
                    state_d = RUNNING;
                end
`ifdef Q2_CLOCK_STEP_EN
                else if (step_p && !stop_p) begin
                    state_d = STOPPING;
                end
`endif
            end
            RUNNING: begin
                if (stop_p) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (start_p && !stop_p) begin
                    state_d = RUNNING;
                end else if (tick && last_phase) begin
                    state_d = STOPPED;
                end
            end
            default: state_d = STOPPED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // div/cdiv are only looked at on reload, so mid-count changes wait for the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == STOPPED) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= bus.cdiv ? bus.div : '0;
        end else begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            sc_q    <= 1'b0;
            ws_q    <= 1'b0;
        end else begin
            sc_q <= tick;
            ws_q <= tick && last_phase;
            if (tick) begin
                phase_q <= last_phase ? '0 : phase_q + PH_W'(1);
            end
        end
    end

    assign bus.running   = (state_q != STOPPED);
    assign bus.phase     = phase_q;
    assign bus.sc        = sc_q;
    assign bus.ws        = ws_q;
    assign bus.dbg_state = state_q;

endmodule
